// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage                                                    |
// | Description : Memory stage of the pipeline. Reads the EX/MEM register     |
// |               outputs and runs the load/store on the single-master bus.    |
// |               It stalls the pipeline until the bus reports ready and       |
// |               flags misaligned accesses. It then updates the MEM/WB        |
// |               register for the write-back and control stages.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset_      : clock, asynchronous active-low reset                  |
// |   Stall, Flush     : pipeline control (hold / clear MEM/WB register)       |
// |   EX*              : EX-stage outputs (PC, valid, branch flag, mem op,     |
// |                      store data, ctrl op, dst GPR, GPR WE_, exception,    |
// |                      ALU result / byte address)                           |
// |   BusRdy_, BusRdData : bus ready (active-low) and read data               |
// |   BusAs_, BusRW, BusAddr, BusWrData : bus strobe, direction, word         |
// |                      address and write data                               |
// |   Busy             : stall request to pipeline control                    |
// |   MEM*             : MEM/WB pipeline register                             |
// +----------------------------------------------------------------------------+
module mem_stage #(
   parameter int WORD_DATA_W = 32,
   parameter int WORD_ADDR_W = 30,
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_OP_W    = 2,
   parameter int CTRL_OP_W   = 2,
   parameter int EXP_W       = 3
) (
   input  logic                   clk,
   input  logic                   reset_,
   input  logic                   Stall,
   input  logic                   Flush,
   input  logic [WORD_ADDR_W-1:0] EXPC,
   input  logic                   EXEn,
   input  logic                   EXBrFlag,
   input  logic [MEM_OP_W-1:0]    EXMemOp,
   input  logic [WORD_DATA_W-1:0] EXMemWrData,
   input  logic [CTRL_OP_W-1:0]   EXCtrlOp,
   input  logic [REG_ADDR_W-1:0]  EXDstAddr,
   input  logic                   EXGPRWE_,
   input  logic [EXP_W-1:0]       EXExpCode,
   input  logic [WORD_DATA_W-1:0] EXOut,
   input  logic                   BusRdy_,
   input  logic [WORD_DATA_W-1:0] BusRdData,
   output logic                   BusAs_,
   output logic                   BusRW,
   output logic [WORD_ADDR_W-1:0] BusAddr,
   output logic [WORD_DATA_W-1:0] BusWrData,
   output logic                   Busy,
   output logic [WORD_ADDR_W-1:0] MEMPC,
   output logic                   MEMEn,
   output logic                   MEMBrFlag,
   output logic [CTRL_OP_W-1:0]   MEMCtrlOp,
   output logic [REG_ADDR_W-1:0]  MEMDstAddr,
   output logic                   MEMGPRWE_,
   output logic [EXP_W-1:0]       MEMExpCode,
   output logic [WORD_DATA_W-1:0] MEMOut
);

   localparam logic [MEM_OP_W-1:0]  c_MEM_OP_NOP     = '0;
   localparam logic [MEM_OP_W-1:0]  c_MEM_OP_LDW     = MEM_OP_W'(1);
   localparam logic [CTRL_OP_W-1:0] c_CTRL_OP_NOP    = '0;
   localparam logic [EXP_W-1:0]     c_EXP_NO_EXP     = '0;
   localparam logic [EXP_W-1:0]     c_EXP_MISS_ALIGN = EXP_W'(4);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [WORD_DATA_W-1:0] r_rd_data;
   logic [WORD_DATA_W-1:0] w_rd_data;
   logic                   w_mem_op;
   logic                   w_aligned;
   logic                   w_req;
   logic                   w_mis;
   logic                   w_load;
   logic                   w_strobe;
   logic                   w_done;
   logic                   w_mem_upd;

   assign w_mem_op  = EXEn & (EXMemOp != c_MEM_OP_NOP);
   assign w_aligned = (EXOut[1:0] == 2'b00);
   // Gated by reset_ so the bus goes quiet the moment reset asserts, even
   // though the EX inputs may still be presenting an access.
   assign w_req     = reset_ & w_mem_op & w_aligned & ~Flush;
   assign w_mis     = w_mem_op & ~w_aligned;
   assign w_load    = (EXMemOp == c_MEM_OP_LDW);

   always_comb begin
      w_state_next = r_state;
      w_strobe     = 1'b0;
      w_done       = 1'b0;
      Busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_strobe = 1'b1;
               if (!BusRdy_) begin
                  w_done       = 1'b1;
                  w_state_next = Stall ? S_DONE : S_IDLE;
               end else begin
                  Busy         = 1'b1;
                  w_state_next = S_WAIT;
               end
            end
         end
         // Flush is deliberately ignored here: a started bus cycle must finish.
         S_WAIT: begin
            w_strobe = 1'b1;
            if (!BusRdy_) begin
               w_done       = 1'b1;
               w_state_next = Stall ? S_DONE : S_IDLE;
            end else begin
               Busy = 1'b1;
            end
         end
         // Access already finished; wait out the stall without re-issuing.
         S_DONE: begin
            if (!Stall) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign BusAs_    = ~w_strobe;
   assign BusRW     = w_strobe ? w_load : 1'b1;
   assign BusAddr   = w_strobe ? EXOut[WORD_DATA_W-1:2] : '0;
   assign BusWrData = w_strobe ? EXMemWrData : '0;

   // In DONE the bus data has moved on; use the copy taken at completion.
   assign w_rd_data = (r_state == S_DONE) ? r_rd_data : BusRdData;
   assign w_mem_upd = ~Stall & ~Busy;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state   <= S_IDLE;
         r_rd_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_done) begin
            r_rd_data <= BusRdData;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         MEMPC      <= '0;
         MEMEn      <= 1'b0;
         MEMBrFlag  <= 1'b0;
         MEMCtrlOp  <= c_CTRL_OP_NOP;
         MEMDstAddr <= '0;
         MEMGPRWE_  <= 1'b1;
         MEMExpCode <= c_EXP_NO_EXP;
         MEMOut     <= '0;
      end else if (w_mem_upd) begin
         if (Flush) begin
            MEMPC      <= '0;
            MEMEn      <= 1'b0;
            MEMBrFlag  <= 1'b0;
            MEMCtrlOp  <= c_CTRL_OP_NOP;
            MEMDstAddr <= '0;
            MEMGPRWE_  <= 1'b1;
            MEMExpCode <= c_EXP_NO_EXP;
            MEMOut     <= '0;
         end else if (w_mis) begin
            MEMPC      <= EXPC;
            MEMEn      <= EXEn;
            MEMBrFlag  <= EXBrFlag;
            MEMCtrlOp  <= c_CTRL_OP_NOP;
            MEMDstAddr <= '0;
            MEMGPRWE_  <= 1'b1;
            MEMExpCode <= c_EXP_MISS_ALIGN;
            MEMOut     <= '0;
         end else begin
            MEMPC      <= EXPC;
            MEMEn      <= EXEn;
            MEMBrFlag  <= EXBrFlag;
            MEMCtrlOp  <= EXCtrlOp;
            MEMDstAddr <= EXDstAddr;
            MEMGPRWE_  <= EXGPRWE_;
            MEMExpCode <= EXExpCode;
            MEMOut     <= (w_mem_op && w_load) ? w_rd_data : EXOut;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage                                                 |
// | Description : Directed self-checking bench for mem_stage with a queue of  |
// |               expected MEM/WB register contents.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset_;
   logic        Stall, Flush;
   logic [29:0] EXPC;
   logic        EXEn, EXBrFlag;
   logic [1:0]  EXMemOp;
   logic [31:0] EXMemWrData;
   logic [1:0]  EXCtrlOp;
   logic [4:0]  EXDstAddr;
   logic        EXGPRWE_;
   logic [2:0]  EXExpCode;
   logic [31:0] EXOut;
   logic        BusRdy_;
   logic [31:0] BusRdData;
   logic        BusAs_, BusRW, Busy;
   logic [29:0] BusAddr;
   logic [31:0] BusWrData;
   logic [29:0] MEMPC;
   logic        MEMEn, MEMBrFlag, MEMGPRWE_;
   logic [1:0]  MEMCtrlOp;
   logic [4:0]  MEMDstAddr;
   logic [2:0]  MEMExpCode;
   logic [31:0] MEMOut;

   typedef struct {
      logic [29:0] pc;
      logic        en;
      logic        br;
      logic [1:0]  ctrl;
      logic [4:0]  dst;
      logic        we_;
      logic [2:0]  exp;
      logic [31:0] out;
   } mem_t;

   mem_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   localparam logic [1:0] NOP = 2'd0, LDW = 2'd1, STW = 2'd2;

   mem_stage dut (
      .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush),
      .EXPC(EXPC), .EXEn(EXEn), .EXBrFlag(EXBrFlag), .EXMemOp(EXMemOp),
      .EXMemWrData(EXMemWrData), .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr),
      .EXGPRWE_(EXGPRWE_), .EXExpCode(EXExpCode), .EXOut(EXOut),
      .BusRdy_(BusRdy_), .BusRdData(BusRdData),
      .BusAs_(BusAs_), .BusRW(BusRW), .BusAddr(BusAddr), .BusWrData(BusWrData),
      .Busy(Busy),
      .MEMPC(MEMPC), .MEMEn(MEMEn), .MEMBrFlag(MEMBrFlag), .MEMCtrlOp(MEMCtrlOp),
      .MEMDstAddr(MEMDstAddr), .MEMGPRWE_(MEMGPRWE_), .MEMExpCode(MEMExpCode),
      .MEMOut(MEMOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [1:0] op, input logic [29:0] pc,
                        input logic [31:0] out, input logic [31:0] wd,
                        input logic [4:0] dst, input logic we_,
                        input logic [1:0] ctrl, input logic br, input logic [2:0] exc);
      EXEn = en; EXMemOp = op; EXPC = pc; EXOut = out; EXMemWrData = wd;
      EXDstAddr = dst; EXGPRWE_ = we_; EXCtrlOp = ctrl; EXBrFlag = br; EXExpCode = exc;
   endtask

   task automatic push(input logic [29:0] pc, input logic en, input logic br,
                       input logic [1:0] ctrl, input logic [4:0] dst, input logic we_,
                       input logic [2:0] exc, input logic [31:0] out);
      mem_t e;
      e.pc = pc; e.en = en; e.br = br; e.ctrl = ctrl; e.dst = dst;
      e.we_ = we_; e.exp = exc; e.out = out;
      sb.push_back(e);
   endtask

   task automatic push_cleared();
      push(30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0);
   endtask

   task automatic check_mem(input string tag);
      mem_t e;
      n_vec++;
      assert (sb.size() != 0) else begin
         n_miss++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".PC"},   32'(MEMPC),      32'(e.pc));
         chk({tag, ".En"},   32'(MEMEn),      32'(e.en));
         chk({tag, ".Br"},   32'(MEMBrFlag),  32'(e.br));
         chk({tag, ".Ctrl"}, 32'(MEMCtrlOp),  32'(e.ctrl));
         chk({tag, ".Dst"},  32'(MEMDstAddr), 32'(e.dst));
         chk({tag, ".WE_"},  32'(MEMGPRWE_),  32'(e.we_));
         chk({tag, ".Exp"},  32'(MEMExpCode), 32'(e.exp));
         chk({tag, ".Out"},  MEMOut,          e.out);
      end
   endtask

   initial begin
      reset_ = 1'b0; Stall = 1'b0; Flush = 1'b0;
      BusRdy_ = 1'b1; BusRdData = 32'd0;
      drive(1'b0, NOP, 30'd0, 32'd0, 32'd0, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
      #12;
      // Reset state
      chk("rst.BusAs_",  32'(BusAs_), 32'd1);
      chk("rst.Busy",    32'(Busy), 32'd0);
      chk("rst.BusRW",   32'(BusRW), 32'd1);
      chk("rst.BusAddr", 32'(BusAddr), 32'd0);
      push_cleared();
      check_mem("rst");
      tick();
      reset_ = 1'b1;
      tick();

      // Zero-wait load
      drive(1'b1, LDW, 30'h11, 32'h40, 32'd0, 5'd5, 1'b0, 2'd1, 1'b1, 3'd0);
      BusRdy_ = 1'b0; BusRdData = 32'hDEADBEEF;
      @(negedge clk);
      chk("zw.BusAs_",  32'(BusAs_), 32'd0);
      chk("zw.BusAddr", 32'(BusAddr), 32'h10);
      chk("zw.BusRW",   32'(BusRW), 32'd1);
      chk("zw.Busy",    32'(Busy), 32'd0);
      push(30'h11, 1'b1, 1'b1, 2'd1, 5'd5, 1'b0, 3'd0, 32'hDEADBEEF);
      tick();
      check_mem("zw");

      // Wait-state store, back-to-back with the load
      drive(1'b1, STW, 30'h12, 32'h200, 32'h12345678, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
      BusRdy_ = 1'b1; BusRdData = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("st.Busy",      32'(Busy), 32'd1);
         chk("st.BusAs_",    32'(BusAs_), 32'd0);
         chk("st.BusRW",     32'(BusRW), 32'd0);
         chk("st.BusWrData", BusWrData, 32'h12345678);
         tick();
         chk("st.hold.PC", 32'(MEMPC), 32'h11);
      end
      BusRdy_ = 1'b0;
      @(negedge clk);
      chk("st.fin.Busy",   32'(Busy), 32'd0);
      chk("st.fin.BusAs_", 32'(BusAs_), 32'd0);
      push(30'h12, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h200);
      tick();
      check_mem("st");

      // Invalid instruction: no access, register loads with En=0
      drive(1'b0, LDW, 30'h13, 32'h55, 32'd0, 5'd3, 1'b1, 2'd0, 1'b0, 3'd0);
      @(negedge clk);
      chk("nop.BusAs_", 32'(BusAs_), 32'd1);
      push(30'h13, 1'b0, 1'b0, 2'd0, 5'd3, 1'b1, 3'd0, 32'h55);
      tick();
      check_mem("nop");

      // Misaligned load
      BusRdy_ = 1'b1;
      drive(1'b1, LDW, 30'h14, 32'h102, 32'd0, 5'd7, 1'b0, 2'd1, 1'b0, 3'd0);
      @(negedge clk);
      chk("mis.BusAs_", 32'(BusAs_), 32'd1);
      chk("mis.Busy",   32'(Busy), 32'd0);
      push(30'h14, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd4, 32'd0);
      tick();
      check_mem("mis");

      // Load completing under Stall
      drive(1'b1, LDW, 30'h15, 32'h300, 32'd0, 5'd9, 1'b0, 2'd0, 1'b0, 3'd0);
      Stall = 1'b1; BusRdy_ = 1'b1;
      @(negedge clk);
      chk("stl.c0.Busy",   32'(Busy), 32'd1);
      chk("stl.c0.BusAs_", 32'(BusAs_), 32'd0);
      tick();
      BusRdy_ = 1'b0; BusRdData = 32'hA5A5A5A5;
      @(negedge clk);
      chk("stl.c1.Busy",   32'(Busy), 32'd0);
      chk("stl.c1.BusAs_", 32'(BusAs_), 32'd0);
      tick();
      BusRdy_ = 1'b1; BusRdData = 32'h0;
      @(negedge clk);
      chk("stl.done.BusAs_", 32'(BusAs_), 32'd1);
      chk("stl.done.Busy",   32'(Busy), 32'd0);
      chk("stl.hold.PC",     32'(MEMPC), 32'h14);
      tick();
      Stall = 1'b0; BusRdData = 32'h5A5A5A5A;
      @(negedge clk);
      chk("stl.rel.BusAs_", 32'(BusAs_), 32'd1);
      push(30'h15, 1'b1, 1'b0, 2'd0, 5'd9, 1'b0, 3'd0, 32'hA5A5A5A5);
      tick();
      check_mem("stl");

      // Flush during WAIT: bus cycle finishes, then register cleared
      drive(1'b1, STW, 30'h17, 32'h500, 32'hCAFEF00D, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
      BusRdy_ = 1'b1;
      @(negedge clk);
      chk("fw.c0.Busy", 32'(Busy), 32'd1);
      tick();
      Flush = 1'b1;
      @(negedge clk);
      chk("fw.c1.Busy",   32'(Busy), 32'd1);
      chk("fw.c1.BusAs_", 32'(BusAs_), 32'd0);
      tick();
      BusRdy_ = 1'b0;
      @(negedge clk);
      chk("fw.fin.Busy",      32'(Busy), 32'd0);
      chk("fw.fin.BusAs_",    32'(BusAs_), 32'd0);
      chk("fw.fin.BusWrData", BusWrData, 32'hCAFEF00D);
      push_cleared();
      tick();
      check_mem("fw");

      // Valid store to repopulate the register, then Flush in IDLE
      Flush = 1'b0;
      drive(1'b1, STW, 30'h18, 32'h600, 32'h1, 5'd0, 1'b1, 2'd2, 1'b0, 3'd0);
      push(30'h18, 1'b1, 1'b0, 2'd2, 5'd0, 1'b1, 3'd0, 32'h600);
      tick();
      check_mem("st2");
      drive(1'b1, STW, 30'h16, 32'h400, 32'h2, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
      Flush = 1'b1;
      @(negedge clk);
      chk("fi.BusAs_", 32'(BusAs_), 32'd1);
      chk("fi.Busy",   32'(Busy), 32'd0);
      push_cleared();
      tick();
      check_mem("fi");
      Flush = 1'b0;

      // Upstream exception passes through, access still performed
      drive(1'b1, LDW, 30'h19, 32'h700, 32'd0, 5'd4, 1'b0, 2'd0, 1'b0, 3'd2);
      BusRdData = 32'h0BADCAFE;
      @(negedge clk);
      chk("exc.BusAs_", 32'(BusAs_), 32'd0);
      push(30'h19, 1'b1, 1'b0, 2'd0, 5'd4, 1'b0, 3'd2, 32'h0BADCAFE);
      tick();
      check_mem("exc");

      // Reset asserted mid-WAIT
      drive(1'b1, LDW, 30'h1A, 32'h100, 32'd0, 5'd6, 1'b0, 2'd0, 1'b0, 3'd0);
      BusRdy_ = 1'b1;
      tick();
      @(negedge clk);
      chk("rw.wait.Busy", 32'(Busy), 32'd1);
      #2 reset_ = 1'b0;
      #1;
      chk("rw.BusAs_",    32'(BusAs_), 32'd1);
      chk("rw.Busy",      32'(Busy), 32'd0);
      chk("rw.MEMGPRWE_", 32'(MEMGPRWE_), 32'd1);
      chk("rw.MEMEn",     32'(MEMEn), 32'd0);
      tick();
      reset_ = 1'b1;
      drive(1'b0, NOP, 30'd0, 32'd0, 32'd0, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0);
      @(negedge clk);
      chk("rw.idle.BusAs_", 32'(BusAs_), 32'd1);
      chk("rw.idle.Busy",   32'(Busy), 32'd0);
      chk("sb.empty",       32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer of the EX/MEM pipeline register. Executes the load/store encoded in the EX-stage outputs over the single-master memory bus, stalling the pipeline until the bus reports ready.
- Detects misaligned accesses and latches the MEM/WB pipeline register (PC, control, destination, exception, result) for the write-back and control stages.

Parameters:
- WORD_DATA_W, 32, data/byte-address width
- WORD_ADDR_W, 30, word address width (byte address [31:2])
- REG_ADDR_W, 5, GPR address width
- MEM_OP_W, 2, mem op code (NOP=0, LDW=1, STW=2)
- CTRL_OP_W, 2, ctrl op code (NOP=0)
- EXP_W, 3, exception code (NO_EXP=0, MISS_ALIGN=4)

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- Stall  in  1  global stall from pipeline control
- Flush  in  1  flush MEM/WB register
- EXPC  in  WORD_ADDR_W  PC of the EX-stage instruction
- EXEn  in  1  EX-stage instruction valid
- EXBrFlag  in  1  branch-delay flag
- EXMemOp  in  MEM_OP_W  memory operation
- EXMemWrData  in  WORD_DATA_W  store data
- EXCtrlOp  in  CTRL_OP_W  control op
- EXDstAddr  in  REG_ADDR_W  destination GPR
- EXGPRWE_  in  1  GPR write enable, active-low
- EXExpCode  in  EXP_W  upstream exception
- EXOut  in  WORD_DATA_W  ALU result / byte address
- BusRdy_  in  1  bus ready, active-low
- BusRdData  in  WORD_DATA_W  bus read data
- BusAs_  out  1  address strobe, active-low
- BusRW  out  1  1=read, 0=write
- BusAddr  out  WORD_ADDR_W  word address = EXOut[31:2]
- BusWrData  out  WORD_DATA_W  = EXMemWrData
- Busy  out  1  stall request to pipeline control
- MEMPC, MEMEn, MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMGPRWE_, MEMExpCode, MEMOut  out  (widths as EX counterparts)  MEM/WB register

Behaviour:
- Reset (async, reset_=0): state=IDLE; BusAs_=1, BusRW=1, BusAddr=0, BusWrData=0, Busy=0; MEMPC=0, MEMEn=0, MEMBrFlag=0, MEMCtrlOp=NOP, MEMDstAddr=0, MEMGPRWE_=1, MEMExpCode=NO_EXP, MEMOut=0; capture register=0. Any in-flight bus access is abandoned.
- Access request (comb): Req = EXEn & (EXMemOp != NOP) & (EXOut[1:0]==0) & ~Flush.
- Misalign (comb): Mis = EXEn & (EXMemOp != NOP) & (EXOut[1:0] != 0). No bus cycle is started.
- FSM states: IDLE, WAIT, DONE.
- IDLE, Req=1: BusAs_=0, BusRW=(op==LDW), BusAddr/BusWrData driven from EX inputs.
  - BusRdy_=0 same cycle (zero-wait): Busy=0; load data taken directly from BusRdData. Next state is DONE if Stall=1, else IDLE.
  - BusRdy_=1: Busy=1, next state WAIT.
- WAIT: BusAs_=0, address/data held (EX inputs are stable because Busy stalls the pipeline).
  - Busy=1 until BusRdy_=0.
  - In the BusRdy_=0 cycle: Busy=0, BusRdData captured. Next state is DONE if Stall=1, else IDLE.
  - Flush during WAIT does not abort the bus cycle.
- DONE: BusAs_=1, Busy=0, no re-issue. Read data is held in the capture register. Return to IDLE on the first cycle with Stall=0; the MEM register updates on that edge.
- Read data source for MEMOut: BusRdData in the completion cycle; the capture register in DONE.
- MEM register update, posedge clk, only when Stall=0 and Busy=0. Priority:
  1. Flush: load reset values.
  2. Mis: copy PC/En/BrFlag; MemOp effects suppressed; CtrlOp=NOP, DstAddr=0, GPRWE_=1, ExpCode=MISS_ALIGN, Out=0.
  3. Otherwise: copy all EX fields. MEMOut = read data if op==LDW, else EXOut.
- EXExpCode != NO_EXP passes through unchanged. A memory access is still performed if Req=1.
- Stall=1 or Busy=1: MEM register holds.
- EXEn=0: no access; register loads with MEMEn=0.
- Back-to-back accesses: a new access may start in IDLE on the cycle after completion, with no idle cycle required.

Test Plan:
- Reset mid-WAIT: LDW at EXOut=0x100, BusRdy_ held 1, pull reset_ low -> BusAs_=1, Busy=0, state IDLE, MEMGPRWE_=1 immediately (async).
- Zero-wait load: LDW EXOut=0x00000040, BusRdy_=0, BusRdData=0xDEADBEEF -> BusAddr=0x10, BusRW=1, Busy=0; next edge MEMOut=0xDEADBEEF, MEMDstAddr=EXDstAddr.
- Wait-state store: STW EXOut=0x200, data 0x12345678, BusRdy_ low after 3 cycles -> Busy=1 for 3 cycles, BusAs_=0 for 4 cycles, BusRW=0, BusWrData=0x12345678; MEMOut=0x200 after completion.
- Misaligned: LDW EXOut=0x102 -> BusAs_ stays 1, Busy=0; MEMExpCode=4, MEMGPRWE_=1, MEMOut=0.
- Completion under Stall: LDW completes with Stall=1 for 2 cycles, BusRdData=0xA5A5A5A5 then changes -> single BusAs_ assertion, state DONE; MEMOut=0xA5A5A5A5 on the first Stall=0 edge.
- Flush: Flush=1 with STW in IDLE -> no bus cycle, MEMEn=0, MEMExpCode=0; Flush=1 during WAIT -> bus cycle completes, then MEM register is cleared.
